// File: rtl/thrust_ctrl_if.sv
// Lever/rotate signal bundle between the input-decode side and thrust_ctrl.
// The master modport is the host/decode side; the slave modport is the sequencer.
interface thrust_ctrl_if;
    logic       mode;
    logic [7:0] analog_y;
    logic [7:0] analog_x;
    logic       thr_up;
    logic       thr_down;
    logic       turn_l_in;
    logic       turn_r_in;
    logic [7:0] THRUST;
    logic       ROT_LEFT_L;
    logic       ROT_RIGHT_L;

    modport master (
        output mode, analog_y, analog_x, thr_up, thr_down, turn_l_in, turn_r_in,
        input  THRUST, ROT_LEFT_L, ROT_RIGHT_L
    );

    modport slave (
        input  mode, analog_y, analog_x, thr_up, thr_down, turn_l_in, turn_r_in,
        output THRUST, ROT_LEFT_L, ROT_RIGHT_L
    );
endinterface

// File: rtl/thrust_ctrl.sv
// Lunar Lander thrust/rotate sequencer: analog or d-pad ramped thrust with
// bumpless hand-over, plus hysteresis-filtered stick rotate requests.
module thrust_ctrl #(
    parameter int TICK_DIV   = 98_425,
    parameter int MAX_THRUST = 254,
    parameter int TURN_ON    = 64,
    parameter int TURN_OFF   = 48
) (
    input  logic          clk_25,
    input  logic          RESET_L,
    thrust_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_acc;
    logic             r_mode_q;
    logic             r_sl;
    logic             r_sr;
    logic [7:0]       r_thrust;
    logic             r_rot_l_n;
    logic             r_rot_r_n;

    logic             w_tick;
    logic [8:0]       w_a_thr;
    logic [7:0]       w_a_clamp;
    logic [7:0]       w_acc_next;
    int               w_ax;
    logic             w_sl_next;
    logic             w_sr_next;
    logic             w_l;
    logic             w_r;

    assign w_tick = (r_cnt == CNT_W'(TICK_DIV - 1));

    // 127 - y never leaves 0..255, so a 9-bit unsigned difference is exact.
    assign w_a_thr   = 9'(9'd127 - {bus.analog_y[7], bus.analog_y});
    assign w_a_clamp = (w_a_thr > 9'(MAX_THRUST)) ? 8'(MAX_THRUST) : w_a_thr[7:0];

    // Mode-entry load beats the ramp tick so the hand-over is bumpless.
    always_comb begin
        w_acc_next = r_acc;
        if (bus.mode && !r_mode_q) begin
            w_acc_next = w_a_clamp;
        end else if (w_tick) begin
            if (bus.thr_up && !bus.thr_down && (r_acc < 8'(MAX_THRUST)))
                w_acc_next = 8'(r_acc + 8'd1);
            else if (bus.thr_down && !bus.thr_up && (r_acc != 8'd0))
                w_acc_next = 8'(r_acc - 8'd1);
        end
    end

    assign w_ax = int'($signed(bus.analog_x));

    always_comb begin
        w_sl_next = r_sl;
        w_sr_next = r_sr;
        if (w_ax < -TURN_ON)       w_sl_next = 1'b1;
        else if (w_ax > -TURN_OFF) w_sl_next = 1'b0;
        if (w_ax > TURN_ON)        w_sr_next = 1'b1;
        else if (w_ax < TURN_OFF)  w_sr_next = 1'b0;
    end

    assign w_l = bus.turn_l_in | w_sl_next;
    assign w_r = bus.turn_r_in | w_sr_next;

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            r_cnt     <= '0;
            r_acc     <= 8'd0;
            r_mode_q  <= 1'b0;
            r_sl      <= 1'b0;
            r_sr      <= 1'b0;
            r_thrust  <= 8'd0;
            r_rot_l_n <= 1'b1;
            r_rot_r_n <= 1'b1;
        end else begin
            r_cnt     <= w_tick ? '0 : CNT_W'(r_cnt + 1'b1);
            r_acc     <= w_acc_next;
            r_mode_q  <= bus.mode;
            r_sl      <= w_sl_next;
            r_sr      <= w_sr_next;
            r_thrust  <= bus.mode ? w_acc_next : w_a_clamp;
            // Opposing requests cancel: both lines stay inactive.
            r_rot_l_n <= ~(w_l & ~w_r);
            r_rot_r_n <= ~(w_r & ~w_l);
        end
    end

    assign bus.THRUST      = r_thrust;
    assign bus.ROT_LEFT_L  = r_rot_l_n;
    assign bus.ROT_RIGHT_L = r_rot_r_n;
endmodule
